rtc_bus_writer: RTL and testbench
=================================

// Module: rtc_bus_writer
// PURPOSE
//  Write-side master for the RTC's multiplexed address/data bus. Each accepted
//  request runs one full write: an address phase, a bus gap, then a data phase.
//  It is the counterpart of the synchronous read-capture register (8-bit data,
//  enable, sync reset), which samples bus data on reads; this block drives the bus.
//  It sits between the RTC control FSM and the top-level tristate pad.
//  The pad is driven as ad_oe ? ad_out : 8'bz.
// PARAMETERS
//  T_SETUP  2  clocks the bus value is stable before the strobe (>=1)
//  T_PULSE  4  clocks cs_n/wr_n are held low (>=1)
//  T_HOLD   2  clocks the bus value is held after the strobe (>=1)
//  T_GAP    4  clocks the bus is released between the address and data phases (>=1)
// PORTS
//  clk      in   1  system clock, rising edge
//  reset    in   1  synchronous, active-high
//  start    in   1  write request; sampled only in IDLE
//  addr     in   8  RTC register address; latched when start is accepted
//  wdata    in   8  write data; latched when start is accepted
//  ad_out   out  8  value driven onto the multiplexed AD bus
//  ad_oe    out  1  AD tristate enable, 1 = drive
//  a_d      out  1  phase qualifier: 0 = address, 1 = data
//  cs_n     out  1  chip select, active-low
//  wr_n     out  1  write strobe, active-low
//  rd_n     out  1  read strobe; held constant at 1 by this block
//  busy     out  1  high from the first phase cycle through the DONE cycle
//  done     out  1  one-cycle pulse marking the end of the transaction
// BEHAVIOUR
//  - Clock and reset: single clk; reset is synchronous and active-high.
//  - Reset values: ad_out=0, ad_oe=0, a_d=1, cs_n=1, wr_n=1, rd_n=1, busy=0,
//    done=0, state=IDLE.
//  - Reset mid-transaction: all outputs return to reset values at the next edge,
//    and the latched addr/wdata are discarded.
//  - All outputs are registered (Moore, decoded from the state register).
//    No combinational path exists from any input to any output.
//  - FSM: IDLE > A_SETUP > A_STROBE > A_HOLD > GAP > D_SETUP > D_STROBE >
//    D_HOLD > DONE > IDLE.
//  - Each timed phase lasts exactly its parameter in clocks (SETUP/PULSE/HOLD/GAP).
//    A per-phase down-counter is loaded with (param-1) on entry; the FSM advances
//    when the counter reaches 0.
//  - Phase outputs (fields not listed keep reset values):
//     A_SETUP  ad_oe=1, ad_out=addr_q, a_d=0
//     A_STROBE as A_SETUP, plus cs_n=0, wr_n=0
//     A_HOLD   as A_SETUP (strobes high)
//     GAP      ad_oe=0, ad_out=0, a_d=1
//     D_SETUP  ad_oe=1, ad_out=wdata_q, a_d=1
//     D_STROBE as D_SETUP, plus cs_n=0, wr_n=0
//     D_HOLD   as D_SETUP
//     DONE     done=1 (bus released)
//  - busy=1 in every state except IDLE.
//  - Latency: start is accepted at edge k. A_SETUP is visible after edge k, and
//    DONE is visible after edge k+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP
//    (k+20 with defaults).
//  - start while busy, including the DONE cycle, is ignored; it is not queued.
//    A start held high through DONE is accepted at the first edge in IDLE.
//    Back-to-back transactions are therefore separated by one IDLE cycle.
//  - addr and wdata are latched only at acceptance; input changes during a
//    transaction have no effect on the bus.
//  - cs_n and wr_n always fall and rise together, and never while a_d or ad_out
//    is changing.
// STRUCTURE
//  - Package rtc_bus_pkg holds the state encoding (localparams), the default
//    timing constants, and the bus idle values. The read controller reuses it.
//  - Sub-module rtc_phase_timer: a loadable 8-bit down-counter with a zero flag.
//    The FSM, operand latches and output register stay in this module.
// TESTING
//  1. Reset: assert reset for 3 clocks -> all outputs equal the reset values;
//     busy=0.
//  2. Single write: start=1 for 1 clock, addr=8'hF1, wdata=8'h5A ->
//     ad_out=F1 with a_d=0 for 8 clocks, cs_n/wr_n low for 4 of them;
//     GAP for 4 clocks with ad_oe=0; ad_out=5A with a_d=1 for 8 clocks, strobe 4;
//     done pulses at cycle k+20.
//  3. Ignored start: start again at k+10 with addr=8'h33 -> the bus still shows
//     F1/5A; no second transaction follows.
//  4. Input change mid-op: wdata changes to 8'hD3 during A_STROBE -> the data
//     phase still drives 5A.
//  5. Reset mid-op: reset=1 during D_STROBE -> next edge cs_n=1, wr_n=1, ad_oe=0,
//     busy=0, and done is never pulsed.
//  6. Back-to-back: start held high with addr=8'h8D then 8'h83 -> two complete
//     transactions with exactly one IDLE cycle between DONE and the next A_SETUP.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus masters: state encoding,
// default phase timing and the value the bus pins rest at when nothing is driving.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 4;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_GAP_DEF   = 4;

    localparam logic [7:0] AD_IDLE     = 8'h00;
    localparam logic       A_D_IDLE    = 1'b1;
    localparam logic       STROBE_IDLE = 1'b1;

    typedef struct packed {
        logic [7:0] ad_out;
        logic       ad_oe;
        logic       a_d;
        logic       cs_n;
        logic       wr_n;
        logic       busy;
        logic       done;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{
        ad_out: AD_IDLE,
        ad_oe:  1'b0,
        a_d:    A_D_IDLE,
        cs_n:   STROBE_IDLE,
        wr_n:   STROBE_IDLE,
        busy:   1'b0,
        done:   1'b0
    };

    // A phase of N clocks is timed by loading N-1 and advancing on zero.
    function automatic logic [7:0] phase_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter; zero_o is high while the count sits at 0.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_writer.sv
// Write master for the RTC multiplexed AD bus: address phase, bus gap, data
// phase. Every output comes straight from a register loaded from the next state.
module rtc_bus_writer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    bus_out_t   out_q, out_d;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_zero;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_A_SETUP;
                addr_d   = addr;
                wdata_d  = wdata;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_SETUP);
            end
            ST_A_SETUP: if (tmr_zero) begin
                state_d  = ST_A_STROBE;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_PULSE);
            end
            ST_A_STROBE: if (tmr_zero) begin
                state_d  = ST_A_HOLD;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_HOLD);
            end
            ST_A_HOLD: if (tmr_zero) begin
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_GAP);
            end
            ST_GAP: if (tmr_zero) begin
                state_d  = ST_D_SETUP;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_SETUP);
            end
            ST_D_SETUP: if (tmr_zero) begin
                state_d  = ST_D_STROBE;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_PULSE);
            end
            ST_D_STROBE: if (tmr_zero) begin
                state_d  = ST_D_HOLD;
                tmr_load = 1'b1;
                tmr_val  = phase_load(T_HOLD);
            end
            ST_D_HOLD: if (tmr_zero) begin
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoding the next state keeps the pins registered yet aligned with the state.
    always_comb begin
        out_d      = BUS_IDLE;
        out_d.busy = (state_d != ST_IDLE);
        unique case (state_d)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                out_d.ad_oe  = 1'b1;
                out_d.ad_out = addr_d;
                out_d.a_d    = 1'b0;
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                out_d.ad_oe  = 1'b1;
                out_d.ad_out = wdata_d;
                out_d.a_d    = 1'b1;
            end
            ST_DONE: out_d.done = 1'b1;
            default: ;
        endcase
        if (state_d == ST_A_STROBE || state_d == ST_D_STROBE) begin
            out_d.cs_n = 1'b0;
            out_d.wr_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            out_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
        end
    end

    assign ad_out = out_q.ad_out;
    assign ad_oe  = out_q.ad_oe;
    assign a_d    = out_q.a_d;
    assign cs_n   = out_q.cs_n;
    assign wr_n   = out_q.wr_n;
    assign busy   = out_q.busy;
    assign done   = out_q.done;
    assign rd_n   = STROBE_IDLE;

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Scoreboard bench for rtc_bus_writer: stimulus queues expected writes, a
// negedge monitor measures each bus transaction and checks it on done.
module tb_rtc_bus_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_out;
    logic       ad_oe, a_d, cs_n, wr_n, rd_n, busy, done;

    rtc_bus_writer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr   (addr),
        .wdata  (wdata),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .a_d    (a_d),
        .cs_n   (cs_n),
        .wr_n   (wr_n),
        .rd_n   (rd_n),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         idle;   // required IDLE cycles before this write, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         start_cyc, last_done = -100, idle_gap;
    int         aph, dph, ast, dst, gapc;
    logic [7:0] acap, dcap;
    logic       prev_valid = 1'b0;
    logic       prev_busy, prev_cs, prev_ad_d;
    logic [7:0] prev_ad;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            chk("strobe_pair", int'(cs_n), int'(wr_n));
            chk("rd_n_high", int'(rd_n), 1);
            if (!ad_oe) chk("released_bus_zero", int'(ad_out), 0);
            if (prev_valid && cs_n !== prev_cs) begin
                chk("strobe_edge_ad_stable", int'(ad_out), int'(prev_ad));
                chk("strobe_edge_ad_phase", int'(a_d), int'(prev_ad_d));
            end
            if (busy && !prev_busy) begin
                start_cyc = cyc;
                idle_gap  = cyc - last_done - 1;
                aph = 0; dph = 0; ast = 0; dst = 0; gapc = 0;
                acap = 8'hxx; dcap = 8'hxx;
            end
            if (ad_oe && !a_d) begin
                aph++;
                if (!cs_n) begin ast++; acap = ad_out; end
            end
            if (ad_oe && a_d) begin
                dph++;
                if (!cs_n) begin dst++; dcap = ad_out; end
            end
            if (busy && !ad_oe && !done) gapc++;
            if (done) begin
                done_cnt++;
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr_value", int'(acap), int'(e.a));
                    chk("data_value", int'(dcap), int'(e.d));
                    chk("addr_phase_len", aph, 8);
                    chk("data_phase_len", dph, 8);
                    chk("addr_strobe_len", ast, 4);
                    chk("data_strobe_len", dst, 4);
                    chk("gap_len", gapc, 4);
                    chk("latency", cyc - start_cyc, 20);
                    if (e.idle >= 0) chk("idle_between", idle_gap, e.idle);
                end
                $display("write done: addr=%02h data=%02h at cycle %0d", acap, dcap, cyc);
            end
            prev_valid = 1'b1;
            prev_busy  = busy;
            prev_cs    = cs_n;
            prev_ad    = ad_out;
            prev_ad_d  = a_d;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d, input int idle);
        exp_t e;
        e.a = a; e.d = d; e.idle = idle;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr = 8'h00; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ad_out", int'(ad_out), 0);
        chk("rst_ad_oe", int'(ad_oe), 0);
        chk("rst_a_d", int'(a_d), 1);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_wr_n", int'(wr_n), 1);
        chk("rst_rd_n", int'(rd_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single write, with an ignored start and a mid-op wdata change
        addr = 8'hF1; wdata = 8'h5A; start = 1'b1;
        push(8'hF1, 8'h5A, -1);
        @(posedge clk); #1;                  // accepted at edge k
        start = 1'b0;
        repeat (3) @(posedge clk); #1;       // inside A_STROBE
        wdata = 8'hD3;
        repeat (7) @(posedge clk); #1;       // k+10
        addr = 8'h33; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("single");
        repeat (25) @(posedge clk); #1;
        chk("no_second_txn_busy", int'(busy), 0);

        // reset during D_STROBE aborts the write without a done pulse
        addr = 8'h11; wdata = 8'h22; start = 1'b1;
        @(posedge clk); #1;                  // accepted at edge k
        start = 1'b0;
        repeat (15) @(posedge clk); #1;      // k+15, D_STROBE
        chk("pre_reset_cs_n", int'(cs_n), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cs_n", int'(cs_n), 1);
        chk("midrst_wr_n", int'(wr_n), 1);
        chk("midrst_ad_oe", int'(ad_oe), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ad_out", int'(ad_out), 0);
        reset = 1'b0;
        repeat (30) @(posedge clk); #1;
        chk("post_rst_idle", int'(busy), 0);

        // back-to-back with start held high
        addr = 8'h8D; wdata = 8'h4C; start = 1'b1;
        push(8'h8D, 8'h4C, -1);
        push(8'h83, 8'h7E, 1);
        @(posedge clk); #1;
        addr = 8'h83; wdata = 8'h7E;
        wait_done("b2b_first");
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!busy && n < 5);
            chk("b2b_restart", int'(busy), 1);
        end
        start = 1'b0;
        wait_done("b2b_second");
        repeat (10) @(posedge clk); #1;

        chk("done_count", done_cnt, 3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
